// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver: 16x oversampling from a free-running divider, 3-sample majority vote per bit.
// Received bytes are handed to the CPU side as a level rx_valid, consumed by a one-cycle rx_ack.
module uart_rx_os16 #(
  parameter int CLK_DIV   = 326,
  parameter int DATA_BITS = 8
) (
  input  logic                 Sys_clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic                 rx_m_q, rx_s_q;
  logic [DIV_W-1:0]     div_q;
  logic                 tick;
  logic [1:0]           state_q, state_d;
  logic [3:0]           s_q, s_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 smp7_q, smp7_d, smp8_q, smp8_d;
  logic                 maj;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 ferr_q, ferr_d;

  // Divider is never re-phased on a start edge; start alignment error stays within one tick.
  assign tick = (div_q == DIV_W'(CLK_DIV - 1));
  assign maj  = (smp7_q & smp8_q) | (smp7_q & rx_s_q) | (smp8_q & rx_s_q);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    smp7_d  = smp7_q;
    smp8_d  = smp8_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = 1'b0;

    if (rx_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    if (tick) begin
      if (s_q == 4'd7) smp7_d = rx_s_q;
      if (s_q == 4'd8) smp8_d = rx_s_q;

      case (state_q)
        S_IDLE: begin
          s_d = 4'd0;
          if (!rx_s_q) state_d = S_START;
        end
        S_START: begin
          s_d = s_q + 4'd1;
          if (s_q == 4'd9 && maj) begin
            state_d = S_IDLE;
            s_d     = 4'd0;
          end else if (s_q == 4'd15) begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end
        S_DATA: begin
          s_d = s_q + 4'd1;
          if (s_q == 4'd9) shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (s_q == 4'd15) begin
            if (idx_q == IDX_W'(DATA_BITS - 1)) state_d = S_STOP;
            else                                idx_d   = idx_q + 1'b1;
          end
        end
        default: begin
          s_d = s_q + 4'd1;
          // Leave at the stop-bit centre so the next start edge is never missed.
          if (s_q == 4'd9) begin
            state_d = S_IDLE;
            s_d     = 4'd0;
            if (maj) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              if (valid_q && !rx_ack) ovr_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge Sys_clk or posedge reset) begin
    if (reset) begin
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      div_q   <= '0;
      state_q <= S_IDLE;
      s_q     <= 4'd0;
      idx_q   <= '0;
      shift_q <= '0;
      smp7_q  <= 1'b0;
      smp8_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_m_q  <= rx;
      rx_s_q  <= rx_m_q;
      div_q   <= tick ? '0 : div_q + 1'b1;
      state_q <= state_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      smp7_q  <= smp7_d;
      smp8_q  <= smp8_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16 at CLK_DIV=4 (one bit = 64 clocks); frame outcomes are scheduled
// from the drive timing and checked every cycle, plus literal end-of-scenario checks.
module tb_uart_rx_os16;

  logic       Sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       rx      = 1'b1;
  logic       rx_ack  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, overrun, frame_err, busy;

  int total = 0;
  int bad   = 0;
  int ferr_seen = 0;
  int busy_seen = 0;

  // Scheduled frame outcome and expected busy window, in cycles since reset release.
  int         cyc = 0;
  int         pend_edge = 0;
  int         pend_kind = 0;  // 0 none, 1 good byte, 2 stop bit low
  logic [7:0] pend_byte = 8'h00;
  int         busy_lo = 1;
  int         busy_hi = 0;

  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       m_ferr  = 1'b0;

  uart_rx_os16 #(.CLK_DIV(4), .DATA_BITS(8)) dut (
    .Sys_clk  (Sys_clk),
    .reset    (reset),
    .rx       (rx),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .overrun  (overrun),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 Sys_clk = ~Sys_clk;

  // Receiver contract: a frame's outcome lands on its scheduled edge, ack clears, completion beats ack.
  always @(posedge Sys_clk or posedge reset) begin
    if (reset) begin
      cyc     <= 0;
      m_data  <= 8'h00;
      m_valid <= 1'b0;
      m_ovr   <= 1'b0;
      m_ferr  <= 1'b0;
    end else begin
      cyc    <= cyc + 1;
      m_ferr <= 1'b0;
      if (cyc + 1 == pend_edge && pend_kind == 1) begin
        m_data  <= pend_byte;
        m_valid <= 1'b1;
        if (rx_ack)       m_ovr <= 1'b0;
        else if (m_valid) m_ovr <= 1'b1;
      end else begin
        if (cyc + 1 == pend_edge && pend_kind == 2) m_ferr <= 1'b1;
        if (rx_ack) begin
          m_valid <= 1'b0;
          m_ovr   <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d t=%0t", nm, act, exp, cyc, $time);
    end
  endtask

  task automatic compare_all();
    chk("rx_data",   rx_data,   m_data);
    chk("rx_valid",  rx_valid,  m_valid);
    chk("overrun",   overrun,   m_ovr);
    chk("frame_err", frame_err, m_ferr);
    chk("busy",      busy,      (cyc >= busy_lo && cyc <= busy_hi));
    if (frame_err === 1'b1) ferr_seen++;
    if (busy === 1'b1) busy_seen++;
  endtask

  // A low driven after edge c is seen by the FSM at edge c+3; ticks fall on edges that are multiples of 4.
  function automatic int next_tick(input int e);
    int t;
    t = e;
    while (t % 4 != 0) t++;
    return t;
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int glitch_bit,
                            input bit ack_done, input int ncyc);
    int c0, t0, e8;
    logic v;
    @(negedge Sys_clk);
    c0 = cyc;
    t0 = next_tick(c0 + 3);
    e8 = t0 + 4 * (25 + 16 * glitch_bit);
    pend_byte = b;
    pend_kind = stop_ok ? 1 : 2;
    pend_edge = t0 + 616;
    busy_lo   = t0;
    busy_hi   = t0 + 615;
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) @(negedge Sys_clk);
      if (i < 64)       v = 1'b0;
      else if (i < 576) v = b[(i - 64) / 64];
      else              v = stop_ok ? 1'b1 : (i >= 620);
      if (glitch_bit >= 0 && c0 + i >= e8 - 5 && c0 + i <= e8 - 2) v = ~v;
      rx     = v;
      rx_ack = ack_done && (c0 + i == t0 + 615);
    end
  endtask

  task automatic false_start();
    int c0, t0;
    @(negedge Sys_clk);
    c0 = cyc;
    t0 = next_tick(c0 + 3);
    pend_kind = 0;
    busy_lo   = t0;
    busy_hi   = t0 + 39;
    rx = 1'b0;
    repeat (12) @(negedge Sys_clk);
    rx = 1'b1;
    repeat (80) @(negedge Sys_clk);
  endtask

  task automatic ack();
    @(negedge Sys_clk);
    rx_ack = 1'b1;
    @(negedge Sys_clk);
    rx_ack = 1'b0;
  endtask

  task automatic check_outs(input string nm, input logic [7:0] d, input logic v, input logic o, input logic b);
    chk({nm, "_data"},  rx_data,  d);
    chk({nm, "_valid"}, rx_valid, v);
    chk({nm, "_ovr"},   overrun,  o);
    chk({nm, "_busy"},  busy,     b);
  endtask

  initial begin
    int f0, b0;
    repeat (3) @(negedge Sys_clk);
    reset = 1'b0;
    #1;
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset_ferr", frame_err, 1'b0);
    fork
      forever begin
        @(negedge Sys_clk);
        #1;
        compare_all();
      end
    join_none

    // Framing error right after reset.
    f0 = ferr_seen;
    send_frame(8'hA3, 1'b0, -1, 1'b0, 640);
    chk("ferr_pulses", ferr_seen - f0, 1);
    check_outs("ferr", 8'h00, 1'b0, 1'b0, 1'b0);

    // False start: busy for exactly START s=0..9.
    b0 = busy_seen; f0 = ferr_seen;
    false_start();
    chk("fstart_busy_cycles", busy_seen - b0, 40);
    chk("fstart_ferr", ferr_seen - f0, 0);
    check_outs("fstart", 8'h00, 1'b0, 1'b0, 1'b0);

    // Good frame, busy for START through STOP s=9.
    b0 = busy_seen; f0 = ferr_seen;
    send_frame(8'h55, 1'b1, -1, 1'b0, 640);
    chk("good_busy_cycles", busy_seen - b0, 616);
    chk("good_ferr", ferr_seen - f0, 0);
    check_outs("good", 8'h55, 1'b1, 1'b0, 1'b0);
    ack();
    check_outs("good_ack", 8'h55, 1'b0, 1'b0, 1'b0);

    // Overrun without ack, then ack clears both.
    send_frame(8'h01, 1'b1, -1, 1'b0, 640);
    send_frame(8'hFF, 1'b1, -1, 1'b0, 640);
    check_outs("ovr", 8'hFF, 1'b1, 1'b1, 1'b0);
    ack();
    check_outs("ovr_ack", 8'hFF, 1'b0, 1'b0, 1'b0);

    // Ack coinciding with the second completion: completion wins, no overrun.
    send_frame(8'h01, 1'b1, -1, 1'b0, 640);
    check_outs("ovr2_first", 8'h01, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, -1, 1'b1, 640);
    check_outs("ovr2_same", 8'hFF, 1'b1, 1'b0, 1'b0);
    ack();

    // Single-sample glitch at s=8 of bit 2 is voted out.
    f0 = ferr_seen;
    send_frame(8'hC4, 1'b1, 2, 1'b0, 640);
    check_outs("noise", 8'hC4, 1'b1, 1'b0, 1'b0);
    chk("noise_ferr", ferr_seen - f0, 0);
    ack();

    // Reset during data bit 4 abandons the frame silently.
    send_frame(8'h3C, 1'b1, -1, 1'b0, 350);
    @(negedge Sys_clk);
    pend_kind = 0;
    busy_lo = 1;
    busy_hi = 0;
    rx = 1'b1;
    reset = 1'b1;
    #1;
    check_outs("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("midrst_ferr", frame_err, 1'b0);
    repeat (3) @(negedge Sys_clk);
    reset = 1'b0;
    repeat (20) @(negedge Sys_clk);
    send_frame(8'h3C, 1'b1, -1, 1'b0, 640);
    check_outs("after_rst", 8'h3C, 1'b1, 1'b0, 1'b0);

    repeat (10) @(negedge Sys_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- UART receiver that samples the serial line at 16x the bit rate. It is the receive-side consumer of the baud-rate timing used by the transmit path.
- Converts the 8N1 serial stream on rx into parallel bytes with a valid/ack handshake to the CPU-side peripheral logic.
- Generates its own 16x sample tick from Sys_clk with an internal divider. Default timing is 19200 baud from a 100 MHz Sys_clk.

Parameters:
- CLK_DIV, 326, Sys_clk cycles per 16x sample tick (100e6 / (19200*16), rounded).
- DATA_BITS, 8, data bits per frame. Frame format is fixed: LSB first, no parity, 1 stop bit.

Ports:
- Sys_clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; asynchronous to Sys_clk; idles high.
- rx_ack  input  1  one-cycle pulse; consumes the held byte and clears rx_valid and overrun.
- rx_data  output  DATA_BITS  last good received byte; held until the next good frame.
- rx_valid  output  1  level; high while an unacknowledged byte sits in rx_data.
- overrun  output  1  sticky; a good frame completed while rx_valid was already 1.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE; divider, sample counter, bit index and shift register clear to 0.
  - Synchronizer flops are set to 1.
  - rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0.
  - Reset mid-frame abandons the frame with no error pulse.
- Synchronizer: 2-flop synchronizer on rx; rx_s is the second flop. All decisions use rx_s only.
- Tick divider:
  - Free-running counter 0..CLK_DIV-1. tick=1 for one Sys_clk when the counter equals CLK_DIV-1, then it wraps to 0.
  - The divider is never re-phased by start detection; alignment error is at most 1/16 bit.
- Sample counter s: 4 bits, advances only on tick, wraps 15->0.
- Majority vote: rx_s is captured at s=7, 8 and 9. maj = majority of the three, evaluated on the s=9 tick.
- FSM (state changes only on tick):
  - IDLE: if rx_s==0, go to START with s=0. Otherwise stay.
  - START:
    - At s=9: if maj==1 it is a false start (glitch); return to IDLE.
    - Otherwise continue. At s=15 go to DATA with bit index 0 and s=0.
  - DATA:
    - At s=9: shift in LSB first (shift <= {maj, shift[DATA_BITS-1:1]}).
    - At s=15: if bit index==DATA_BITS-1, go to STOP with s=0; else increment bit index.
  - STOP, at s=9:
    - maj==1: rx_data <= shift and rx_valid <= 1. If rx_valid was already 1 and rx_ack is not asserted in the same cycle, overrun <= 1.
    - maj==0: frame_err pulses for 1 cycle; rx_data, rx_valid and overrun are unchanged.
    - Either way go to IDLE immediately. This leaves about half a bit of margin before the next start edge.
- Handshake:
  - rx_ack clears rx_valid and overrun on the next edge.
  - If rx_ack and a good-frame completion occur in the same cycle, completion wins: rx_valid stays 1, overrun is not set, and rx_data takes the new byte.
  - rx_ack while rx_valid=0 has no effect.
- Latency: rx_valid rises on the STOP s=9 tick, i.e. about 9.6 bit times after the start edge, plus 2-3 Sys_clk of synchronizer delay.
- Line held low forever: each attempt yields a frame_err (stop low), then the FSM re-enters START on the next tick. No lockup.

Test Plan:
- All scenarios use CLK_DIV=4, so 1 bit = 64 Sys_clk.
- Good frame: drive frame 0x55 -> rx_valid=1, rx_data=0x55, frame_err never pulses, busy=0 after the stop sample; rx_ack -> rx_valid=0.
- False start: rx low for 12 Sys_clk (3 ticks) while idle -> busy rises, then falls at START s=9; rx_valid stays 0 and frame_err stays 0.
- Framing error: frame 0xA3 with stop bit driven 0 -> exactly one frame_err pulse; rx_valid=0; rx_data still holds its previous value (0 after reset).
- Overrun: back-to-back frames 0x01 and 0xFF with no ack -> rx_data=0xFF, rx_valid=1, overrun=1; rx_ack -> both 0. A repeat with ack in the same cycle as the second completion -> rx_valid=1, overrun=0.
- Noise filter: in frame 0xC4, invert rx for 4 Sys_clk around sample s=8 of bit 2 -> rx_data=0xC4, no error.
- Reset mid-frame: assert reset during data bit 4 of 0x3C -> all outputs 0 immediately; after release, a full frame 0x3C -> rx_data=0x3C, rx_valid=1.
